// File: rtl/adder_tree_scheduler.sv
// adder_tree_scheduler: round-robin issue of two requesters into a float adder tree with credit-limited result FIFO.
// Optional statistics counters are built only when ADDER_TREE_SCHED_STATS_EN is defined.
module adder_tree_scheduler #(
    parameter int NUM_ELEMENTS = 52,
    parameter int DATA_WIDTH   = 32,
    parameter int TREE_LATENCY = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int TAG_WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s0_valid,
    output logic                  s0_ready,
    input  logic [TAG_WIDTH-1:0]  s0_tag,
    input  logic                  s1_valid,
    output logic                  s1_ready,
    input  logic [TAG_WIDTH-1:0]  s1_tag,
    output logic                  tree_sel,
    output logic                  tree_issue,
    input  logic [DATA_WIDTH-1:0] tree_result,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [TAG_WIDTH-1:0]  m_tag,
    output logic                  m_src,
    input  logic                  flush,
    output logic                  flush_done,
    output logic [31:0]           issue_count,
    output logic [31:0]           stall_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t                  state_q, state_d;
    logic                    prio_q, prio_d;
    logic [CW-1:0]           inflight_q, inflight_d, count_q, count_d;
    logic [AW-1:0]           wptr_q, rptr_q;
    logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [TAG_WIDTH-1:0]    tagm_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   srcm_q;
    logic [TREE_LATENCY-1:0] pv_q, ps_q;
    logic [TAG_WIDTH-1:0]    pt_q [TREE_LATENCY];
    logic                    run, credit, g0, g1, done, pop;

    // Outstanding work (in tree plus buffered) may never exceed the FIFO, so writes never overflow.
    assign credit     = ({1'b0, inflight_q} + {1'b0, count_q}) < (CW+1)'(FIFO_DEPTH);
    assign run        = (state_q == RUN) && !rst;
    assign g0         = s0_valid && (!prio_q || !s1_valid);
    assign g1         = s1_valid && (prio_q || !s0_valid);
    assign s0_ready   = run && credit && g0;
    assign s1_ready   = run && credit && g1;
    assign tree_issue = s0_ready || s1_ready;
    assign tree_sel   = s1_ready;
    assign done       = pv_q[TREE_LATENCY-1];
    assign m_valid    = count_q != '0;
    assign pop        = m_valid && m_ready;
    assign m_data     = mem_q[rptr_q];
    assign m_tag      = tagm_q[rptr_q];
    assign m_src      = srcm_q[rptr_q];
    assign flush_done = state_q == DONE;

    always_comb begin
        state_d    = (state_q == RUN && flush) ? DRAIN :
                     (state_q == DRAIN && inflight_q == '0 && count_q == '0) ? DONE :
                     (state_q == DONE) ? RUN : state_q;
        prio_d     = tree_issue ? !tree_sel : prio_q;
        inflight_d = inflight_q + CW'(tree_issue) - CW'(done);
        count_d    = count_q + CW'(done) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            prio_q     <= 1'b0;
            inflight_q <= '0;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            pv_q       <= '0;
            ps_q       <= '0;
            srcm_q     <= '0;
            for (int i = 0; i < TREE_LATENCY; i++) pt_q[i] <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i]  <= '0;
                tagm_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            pv_q       <= (pv_q << 1) | TREE_LATENCY'(tree_issue);
            ps_q       <= (ps_q << 1) | TREE_LATENCY'(tree_sel);
            pt_q[0]    <= tree_sel ? s1_tag : s0_tag;
            for (int i = 1; i < TREE_LATENCY; i++) pt_q[i] <= pt_q[i-1];
            if (done) begin
                mem_q[wptr_q]  <= tree_result;
                tagm_q[wptr_q] <= pt_q[TREE_LATENCY-1];
                srcm_q[wptr_q] <= ps_q[TREE_LATENCY-1];
                wptr_q         <= wptr_q + AW'(1);
            end
            if (pop) rptr_q <= rptr_q + AW'(1);
        end
    end

`ifdef ADDER_TREE_SCHED_STATS_EN
    logic [31:0] issue_q, stall_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_q <= '0;
            stall_q <= '0;
        end else begin
            issue_q <= issue_q + 32'(tree_issue);
            stall_q <= stall_q + 32'((s0_valid || s1_valid) && !tree_issue);
        end
    end
    assign issue_count = issue_q;
    assign stall_count = stall_q;
`else
    assign issue_count = '0;
    assign stall_count = '0;
`endif
endmodule
